muldiv_hilo_ctrl: RTL and testbench
===================================

# muldiv_hilo_ctrl

Sequencer for the EX-stage multiply/divide resources. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and drives the fixed-latency `mul` unit and the iterative `div` unit. It raises the pipeline stall request while an operation is in flight and owns the architectural HI/LO registers. It replaces ad-hoc per-instruction stall logic in EX with one FSM.

## Interface
Parameters:
- `MUL_LAT`, default 2: cycles from stable `mul_a/mul_b` to a valid `mul_result`; legal range 1..7.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `op_valid` in 1: EX holds a valid instruction this cycle.
- `op_code` in 3: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- `src_a` in 32: rs value (dividend / multiplicand / MT source).
- `src_b` in 32: rt value.
- `stall_in` in 1: a later stage holds EX this cycle.
- `flush` in 1: cancel the instruction in EX.
- `mul_signed` out 1: signed-multiply select.
- `mul_a` out 32, `mul_b` out 32: multiplier operands.
- `mul_result` in 64: multiplier product, {hi, lo}.
- `div_start` out 1: divider start, held while waiting.
- `div_annul` out 1: one-cycle divider abort.
- `div_signed` out 1: signed-divide select.
- `div_a` out 32, `div_b` out 32: divider operands.
- `div_result` in 64: {remainder, quotient}.
- `div_ready` in 1: `div_result` valid this cycle.
- `stallreq` out 1: request to stall IF..EX.
- `hi` out 32, `lo` out 32: architectural HI/LO registers.
- `hilo_we` out 2: one-cycle pulse, bit1 = HI written, bit0 = LO written.

## Operation
- **FSM states:** IDLE, MUL_WAIT, DIV_WAIT, DONE.
- **Operand latch:** on leaving IDLE for a mul/div, latch `src_a`, `src_b` and signedness into internal regs. `mul_*` and `div_*` operand outputs are driven from these regs and are zero in IDLE/DONE.
- **IDLE:**
  - MTHI/MTLO with `op_valid & ~flush` writes `hi`/`lo` = `src_a` at the edge, pulses the matching `hilo_we` bit, no stall.
  - MULT/MULTU goes to MUL_WAIT and clears the counter.
  - DIV/DIVU with `src_b != 0` goes to DIV_WAIT.
  - DIV/DIVU with `src_b == 0` skips the divider: `hi <= src_a`, `lo <= 32'hFFFF_FFFF`, `hilo_we = 2'b11`, go to DONE.
- **MUL_WAIT:**
  - Counter increments each cycle.
  - When counter == `MUL_LAT-1`: `{hi, lo} <= mul_result`, `hilo_we = 2'b11`, go to DONE.
- **DIV_WAIT:**
  - `div_start = ~div_ready`.
  - On `div_ready`: `hi <= div_result[63:32]`, `lo <= div_result[31:0]`, `hilo_we = 2'b11`, go to DONE.
- **DONE:**
  - `stallreq = 0` so EX advances.
  - `op_valid` is ignored, so the same instruction never restarts.
  - Go to IDLE when `stall_in == 0`; otherwise remain in DONE.
- **flush in MUL_WAIT/DIV_WAIT:**
  - Go to IDLE, no HI/LO write.
  - `div_annul = 1` for one cycle if in DIV_WAIT.
  - `flush` has priority over a same-cycle `div_ready` or counter terminal.
- **flush in IDLE:** no operation is started or written.
- **stallreq:**
  - Combinational 1 in IDLE when `op_valid & ~flush` and op is MULT/MULTU, or DIV/DIVU with `src_b != 0`.
  - 1 in MUL_WAIT and DIV_WAIT unless `flush`.
  - 0 otherwise.
- **Reset** (`resetn` = 0, at any time, including mid-operation):
  - state IDLE, counter 0, `hi = lo = 0`, all outputs 0.
  - No annul is issued; the divider is reset by the same `resetn`.

## Timing
- MTHI/MTLO: `hi`/`lo` visible the cycle after issue; zero stall.
- MULT/MULTU:
  - Issue cycle (IDLE, stalled), then `MUL_WAIT` × `MUL_LAT` cycles (stalled), then DONE (released).
  - `stallreq` high for `MUL_LAT+1` cycles.
  - HI/LO valid from the first DONE cycle.
- DIV/DIVU:
  - Stalled from the issue cycle through the `div_ready` cycle.
  - HI/LO valid in the following DONE cycle.
- Divide by zero: 1 stall-free issue cycle, then DONE.
- `hilo_we` is high exactly in the cycle the register update is clocked; it is never high in DONE.
- Back-to-back mul/div ops: the second is accepted only after DONE→IDLE, giving a minimum spacing of `MUL_LAT+2` cycles for mul→mul.

## Test plan
- **MULT, signed:** `MUL_LAT` = 2, MULT `src_a` = 0xFFFF_FFFE, `src_b` = 3 → `stallreq` high 3 cycles; then `hi` = 0xFFFF_FFFF, `lo` = 0xFFFF_FFFA, `hilo_we` = 11 once.
- **DIVU:** `src_a` = 100, `src_b` = 7, `div_ready` 33 cycles after issue → `div_start` high until ready; `hi` = 2, `lo` = 14; `stallreq` falls in DONE.
- **DIV by zero:** `src_a` = 5, `src_b` = 0 → no stall, `div_start` never asserted; `hi` = 5, `lo` = 0xFFFF_FFFF next cycle.
- **Flush mid-divide:** flush at cycle 10 of DIV_WAIT with `div_ready` simultaneously high → `div_annul` pulses once, `hi`/`lo` unchanged, state IDLE.
- **DONE hold:** `stall_in` = 1 for 3 cycles in DONE with `op_valid` still high and MULT → no restart, single `hilo_we` pulse, IDLE after `stall_in` drops.
- **MTLO then reset:** MTLO 0x1234 → `lo` = 0x1234; start MULT, assert `resetn` = 0 mid-MUL_WAIT → `hi` = `lo` = 0 and `stallreq` = 0 immediately (asynchronous).

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: EX-stage multiply/divide sequencer owning HI/LO and the stall request.
// Drives a fixed-latency multiplier and an iterative divider from latched operands.
module muldiv_hilo_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        stall_in,
    input  logic        flush,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        stallreq,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  hilo_we
);
    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] op_a, op_b;
    logic        op_sgn;
    logic        in_mul, in_div, go, is_mul, is_div;
    logic        start_mul, start_div, div_zero, mt_hi, mt_lo, mul_done, div_done;

    assign in_mul    = state == MUL_WAIT;
    assign in_div    = state == DIV_WAIT;
    assign go        = state == IDLE && op_valid && !flush;
    assign is_mul    = op_code == 3'd1 || op_code == 3'd2;
    assign is_div    = op_code == 3'd3 || op_code == 3'd4;
    assign start_mul = go && is_mul;
    assign start_div = go && is_div && src_b != '0;
    assign div_zero  = go && is_div && src_b == '0;
    assign mt_hi     = go && op_code == 3'd5;
    assign mt_lo     = go && op_code == 3'd6;
    assign mul_done  = in_mul && !flush && cnt == 3'(MUL_LAT - 1);
    assign div_done  = in_div && !flush && div_ready;

    // strobes are gated by resetn so they drop at once even while EX still presents an op
    assign stallreq   = resetn && (start_mul || start_div || ((in_mul || in_div) && !flush));
    assign hilo_we    = resetn ? {mt_hi || div_zero || mul_done || div_done,
                                  mt_lo || div_zero || mul_done || div_done} : 2'b00;
    assign div_start  = resetn && in_div && !div_ready;
    assign div_annul  = resetn && in_div && flush;
    assign mul_signed = in_mul && op_sgn;
    assign mul_a      = in_mul ? op_a : '0;
    assign mul_b      = in_mul ? op_b : '0;
    assign div_signed = in_div && op_sgn;
    assign div_a      = in_div ? op_a : '0;
    assign div_b      = in_div ? op_b : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_sgn <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mul || start_div) begin
                        state  <= start_mul ? MUL_WAIT : DIV_WAIT;
                        cnt    <= '0;
                        op_a   <= src_a;
                        op_b   <= src_b;
                        op_sgn <= op_code == 3'd1 || op_code == 3'd3;
                    end else if (div_zero) begin
                        state <= DONE;
                        hi    <= src_a;
                        lo    <= '1;
                    end
                    if (mt_hi) hi <= src_a;
                    if (mt_lo) lo <= src_a;
                end
                MUL_WAIT: begin
                    cnt <= cnt + 3'd1;
                    if (flush) state <= IDLE;
                    else if (mul_done) begin
                        state    <= DONE;
                        {hi, lo} <= mul_result;
                    end
                end
                DIV_WAIT: begin
                    if (flush) state <= IDLE;
                    else if (div_ready) begin
                        state    <= DONE;
                        {hi, lo} <= div_result;
                    end
                end
                DONE: if (!stall_in) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: randomized bench for muldiv_hilo_ctrl against an arithmetic HI/LO model.
module tb_muldiv_hilo_ctrl;
    localparam int ML = 2;

    logic        clk = 1'b0, resetn = 1'b0, op_valid = 1'b0, stall_in = 1'b0, flush = 1'b0;
    logic [2:0]  op_code = '0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        mul_signed, div_start, div_annul, div_signed, div_ready = 1'b0, stallreq;
    logic [31:0] mul_a, mul_b, div_a, div_b, hi, lo;
    logic [63:0] mul_result = '0, div_result = '0;
    logic [1:0]  hilo_we;
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] e_hi = '0, e_lo = '0;

    muldiv_hilo_ctrl #(.MUL_LAT(ML)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_code(op_code),
        .src_a(src_a), .src_b(src_b), .stall_in(stall_in), .flush(flush),
        .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
        .div_a(div_a), .div_b(div_b), .div_result(div_result), .div_ready(div_ready),
        .stallreq(stallreq), .hi(hi), .lo(lo), .hilo_we(hilo_we)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mul_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return sa * sb;
    endfunction

    function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int q, r;
        if (!sgn) return {a % b, a / b};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
    endfunction

    // multiplier stand-in: product of the presented operands, one register stage deep
    always @(posedge clk) mul_result <= mul_ref(mul_signed, mul_a, mul_b);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_mt(input logic to_hi, input logic [31:0] v, input logic fl);
        op_valid = 1'b1;
        op_code  = to_hi ? 3'd5 : 3'd6;
        src_a    = v;
        flush    = fl;
        #1;
        chk("mt_strobe", {stallreq, hilo_we}, fl ? 3'b000 : (to_hi ? 3'b010 : 3'b001));
        tick();
        op_valid = 1'b0;
        flush    = 1'b0;
        if (!fl && to_hi) e_hi = v;
        if (!fl && !to_hi) e_lo = v;
        chk("mt_hilo", {hi, lo}, {e_hi, e_lo});
    endtask

    task automatic do_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold, input int fl);
        int stalls = 0, we = 0, bad = 0;
        op_valid = 1'b1;
        op_code  = sgn ? 3'd1 : 3'd2;
        src_a    = a;
        src_b    = b;
        for (int k = 0; k <= ML; k++) begin
            flush = fl != 0 && k == fl;
            #1;
            if (stallreq) stalls++;
            if (hilo_we != 2'b00) begin
                we++;
                if (hilo_we != 2'b11) bad++;
            end
            tick();
            if (flush) break;
        end
        flush = 1'b0;
        if (fl == 0) begin
            {e_hi, e_lo} = mul_ref(sgn, a, b);
            for (int h = 0; h <= hold; h++) begin
                stall_in = h < hold;
                #1;
                if (stallreq || hilo_we != 2'b00) bad++;
                tick();
            end
            stall_in = 1'b0;
        end
        op_valid = 1'b0;
        #1;
        if (stallreq) bad++;
        chk("mul_stall", 64'(stalls), fl != 0 ? 64'(fl) : 64'(ML + 1));
        chk("mul_we", 64'(we), fl != 0 ? 64'd0 : 64'd1);
        chk("mul_hilo", {hi, lo}, {e_hi, e_lo});
        chk("mul_seq", 64'(bad), 64'd0);
        tick();
    endtask

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int lat, input int fl);
        int stalls = 0, we = 0, bad = 0, st = 0, ann = 0;
        op_valid = 1'b1;
        op_code  = sgn ? 3'd3 : 3'd4;
        src_a    = a;
        src_b    = b;
        if (b == 0) begin
            #1;
            chk("dz_issue", {stallreq, div_start, hilo_we}, 4'b0011);
            tick();
            {e_hi, e_lo} = {a, 32'hFFFF_FFFF};
            #1;
            chk("dz_done", {stallreq, div_start, hilo_we}, 4'b0000);
            chk("dz_hilo", {hi, lo}, {e_hi, e_lo});
            tick();
            op_valid = 1'b0;
            #1;
            chk("dz_idle", 64'(stallreq), 64'd0);
            return;
        end
        for (int k = 0; k <= lat; k++) begin
            div_ready  = k == lat;
            flush      = fl != 0 && k == fl;
            div_result = div_ready ? div_ref(sgn, a, b) : {$urandom, $urandom};
            #1;
            if (stallreq) stalls++;
            if (div_start) st++;
            if (div_annul) ann++;
            if (hilo_we != 2'b00) begin
                we++;
                if (hilo_we != 2'b11) bad++;
            end
            if (k >= 1 && {div_a, div_b, div_signed} != {a, b, sgn}) bad++;
            tick();
            if (flush) break;
        end
        div_ready = 1'b0;
        flush     = 1'b0;
        if (fl == 0) begin
            {e_hi, e_lo} = div_ref(sgn, a, b);
            #1;
            if (stallreq || div_start || hilo_we != 2'b00) bad++;
            tick();
            chk("div_start_cnt", 64'(st), 64'(lat - 1));
        end
        op_valid = 1'b0;
        #1;
        if (stallreq || div_annul || div_start) bad++;
        chk("div_stall", 64'(stalls), fl != 0 ? 64'(fl) : 64'(lat + 1));
        chk("div_we_annul", {32'(we), 32'(ann)}, fl != 0 ? {32'd0, 32'd1} : {32'd1, 32'd0});
        chk("div_hilo", {hi, lo}, {e_hi, e_lo});
        chk("div_seq", 64'(bad), 64'd0);
        tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_ctl", {stallreq, hilo_we, div_start, div_annul, mul_signed, div_signed}, 7'd0);
        chk("rst_ops", {mul_a | mul_b, div_a | div_b}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        do_mul(1'b1, 32'hFFFF_FFFE, 32'd3, 0, 0);
        do_div(1'b0, 32'd100, 32'd7, 33, 0);
        do_div(1'b0, 32'd5, 32'd0, 0, 0);
        do_div(1'b1, 32'hFFFF_FF00, 32'd0, 0, 0);
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 10, 10);
        do_mul(1'b1, 32'h0001_2345, 32'hFFFF_0001, 3, 0);
        do_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, ML);
        do_mt(1'b1, 32'hCAFE_0001, 1'b1);

        op_valid = 1'b1;
        op_code  = 3'd1;
        flush    = 1'b1;
        #1;
        chk("idle_flush", {stallreq, hilo_we}, 3'b000);
        tick();
        op_valid = 1'b0;
        flush    = 1'b0;
        #1;
        chk("idle_flush_nostart", 64'(stallreq), 64'd0);
        tick();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            logic sgn;
            int lat;
            a   = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 1000);
            b   = $urandom_range(0, 1) ? $urandom : $urandom_range(1, 50);
            sgn = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 12);
            case ($urandom_range(0, 4))
                0: do_mt(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 3) == 0));
                1: do_mul(sgn, a, b, $urandom_range(0, 2), $urandom_range(0, 3) == 0 ? $urandom_range(1, ML) : 0);
                2: begin
                    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
                    do_div(sgn, a, b, lat, $urandom_range(0, 3) == 0 ? $urandom_range(1, lat) : 0);
                end
                3: do_div(sgn, a, 32'd0, 0, 0);
                default: do_mul(sgn, a, b, 0, 0);
            endcase
        end

        do_mt(1'b0, 32'h0000_1234, 1'b0);
        op_valid = 1'b1;
        op_code  = 3'd1;
        src_a    = 32'h0000_0010;
        src_b    = 32'h0000_0020;
        tick();
        #1;
        resetn = 1'b0;
        #1;
        e_hi = '0;
        e_lo = '0;
        chk("async_rst_hilo", {hi, lo}, {e_hi, e_lo});
        chk("async_rst_ctl", {stallreq, hilo_we, div_start, div_annul}, 5'd0);
        op_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        do_mul(1'b0, 32'd6, 32'd7, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
